wbgpio_driver: RTL and testbench
================================

// Module: wbgpio_driver
// PURPOSE
//  Wishbone (pipelined, B4) initiator that drives a remote GPIO register using the
//  set/clear-mask word format: bits[31:16]=mask, bits[15:0]=value. Accepts single
//  read/write commands from local logic and optionally polls the GPIO input half,
//  raising an interrupt on change. Sits between a control FSM and the GPIO slave.
// PARAMETERS
//  AW          30      Wishbone word-address width
//  GPIO_ADDR   0       word address of the GPIO register (AW bits)
//  TIMEOUT     1024    cycles with CYC high and no ACK/ERR before abort (>=2)
//  POLL_CYCLES 100000  idle cycles between poll reads (>=2; used only with poll option)
// PORTS
//  i_clk        in   1   clock; all logic on rising edge
//  i_reset_n    in   1   asynchronous, active-low reset
//  i_cmd_valid  in   1   command request
//  o_cmd_ready  out  1   high only in IDLE; command accepted when valid&&ready
//  i_cmd_we     in   1   1=write, 0=read
//  i_cmd_mask   in   16  bits to change (write only)
//  i_cmd_value  in   16  new values for masked bits (write only)
//  o_wb_cyc     out  1   bus cycle
//  o_wb_stb     out  1   strobe
//  o_wb_we      out  1   write enable
//  o_wb_addr    out  AW  always GPIO_ADDR
//  o_wb_data    out  32  {mask, value & mask} on write; 0 on read
//  o_wb_sel     out  4   always 4'hf
//  i_wb_stall   in   1   slave stall
//  i_wb_ack     in   1   slave ack (may arrive in same cycle as accepted STB)
//  i_wb_err     in   1   slave error
//  i_wb_data    in   32  read data
//  o_rsp_valid  out  1   one-cycle pulse: command finished (no backpressure)
//  o_rsp_err    out  1   qualifies o_rsp_valid: ERR or timeout
//  o_rsp_data   out  32  read data, held until next response; 0 after write
//  o_gpio_in    out  16  last polled input half (i_wb_data[31:16])
//  o_int        out  1   one-cycle pulse when polled input differs from o_gpio_in
// BEHAVIOUR
//  Reset: every output 0 except o_cmd_ready=1, o_wb_sel=4'hf, o_wb_addr=GPIO_ADDR;
//   FSM -> IDLE. Reset mid-transaction drops CYC/STB asynchronously; nothing reported.
//  FSM IDLE -> REQ on command accept (or on poll due); CYC=STB=1 next cycle.
//  REQ: hold STB and data until !i_wb_stall. ACK/ERR with STB&&!stall -> DONE directly;
//   otherwise -> WAIT with STB=0, CYC=1.
//  WAIT: ACK or ERR -> DONE. Timeout counter starts at CYC rise; at TIMEOUT-1 with no
//   ACK/ERR -> DONE with error. ACK and ERR together: ERR wins.
//  DONE (1 cycle): CYC=0; pulse o_rsp_valid for commands; -> IDLE. Stale ACK after
//   abort ignored. Min latency accept->rsp_valid = 3 cycles (REQ, DONE, rsp).
//  Read data captured on ACK cycle; write response returns o_rsp_data=0.
//  Command and poll due same cycle: command wins; poll stays pending.
// CONFIGURATION
//  WBGPIO_DRIVER_POLL_EN defined: poll counter counts IDLE cycles; at POLL_CYCLES
//   issues internal read (no o_rsp_valid); on ACK updates o_gpio_in, pulses o_int next
//   cycle if changed; first poll after reset also pulses o_int if nonzero. Poll ERR or
//   timeout: silently dropped, counter restarts.
//  Not defined: no poll logic; o_gpio_in=0, o_int=0 constant; POLL_CYCLES unused.
// STRUCTURE
//  Package wbgpio_driver_pkg: FSM state encoding (IDLE/REQ/WAIT/DONE), width of
//   timeout counter, WB_SEL_ALL=4'hf, mask/value field positions.
//  Sub-module wbgpio_driver_timer: loadable down-counter with expired flag, instanced
//   for timeout and (under macro) poll interval.
// TESTING
//  1 write mask=0x0001 value=0x0001, slave acks with STB -> o_wb_data=0x00010001, rsp
//    pulse 3 cycles after accept, err=0.
//  2 read, slave stalls 4 cycles then acks 2 later with 0xABCD1234 -> STB held 5 cycles,
//    o_rsp_data=0xABCD1234.
//  3 no ACK, TIMEOUT=16 -> CYC drops after 16 cycles, o_rsp_err=1; late ACK ignored.
//  4 ACK+ERR same cycle -> o_rsp_err=1; valid held while busy -> o_cmd_ready=0 throughout.
//  5 (POLL_EN, POLL_CYCLES=8) input half 0x0000->0x0040 -> o_gpio_in=0x0040, one o_int
//    pulse; unchanged next poll -> no pulse; command at poll-due cycle served first.
//  6 reset asserted in WAIT -> CYC/STB low immediately, no rsp; recovers to IDLE.

Source files
------------

// File: rtl/wbgpio_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wbgpio_driver_pkg
// Description : Shared definitions for the Wishbone GPIO driver. Holds the
//               FSM state encoding, the timeout counter width, the bus
//               select constant, the set/clear-mask word field positions
//               and a helper that packs a mask/value pair into a bus word.
// Revision    : 1.0 - initial release
// ============================================================================
package wbgpio_driver_pkg;

    // FSM state encoding
    localparam int c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_req  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_wait = 2'd2;
    localparam logic [c_state_w-1:0] c_st_done = 2'd3;

    // Timeout counter width; covers TIMEOUT values up to 65536
    localparam int c_tmo_cnt_w = 16;

    // All byte lanes are always selected
    localparam logic [3:0] c_wb_sel_all = 4'hf;

    // Set/clear-mask word layout: mask in the upper half, value in the lower
    localparam int c_field_w   = 16;
    localparam int c_mask_msb  = 31;
    localparam int c_mask_lsb  = 16;
    localparam int c_value_msb = 15;
    localparam int c_value_lsb = 0;

    // Value bits outside the mask are forced to zero so the slave never sees
    // stray data in lanes it is told to leave alone.
    function automatic logic [31:0] pack_set_clear(
        input logic [c_field_w-1:0] mask,
        input logic [c_field_w-1:0] value
    );
        logic [31:0] word;
        word = '0;
        word[c_mask_msb:c_mask_lsb]   = mask;
        word[c_value_msb:c_value_lsb] = value & mask;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbgpio_driver_timer.sv
`default_nettype none
// ============================================================================
// Module      : wbgpio_driver_timer
// Description : Loadable down-counter with an expired flag. The count sits
//               at zero once it gets there, so the expired flag stays high
//               until the next load.
// Revision    : 1.0 - initial release
// Ports       :
//   i_clk        in   1  clock, rising edge
//   i_reset_n    in   1  asynchronous active-low reset (count <- RESET_VAL)
//   i_load       in   1  load i_load_value (has priority over i_en)
//   i_load_value in   W  value to load
//   i_en         in   1  decrement enable
//   o_expired    out  1  count is zero
// ============================================================================
module wbgpio_driver_timer #(
    parameter int             W         = 16,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wbgpio_driver.sv
`default_nettype none
// ============================================================================
// Module      : wbgpio_driver
// Description : Pipelined Wishbone B4 initiator driving a remote GPIO
//               register in set/clear-mask format ({mask, value & mask}).
//               Serves single read/write commands from local logic. With
//               WBGPIO_DRIVER_POLL_EN defined it also polls the register
//               and pulses o_int when the input half changes.
// Revision    : 1.0 - initial release
// Config      : WBGPIO_DRIVER_POLL_EN - enables the periodic input poll
// Ports       :
//   i_clk, i_reset_n                  clock, async active-low reset
//   i_cmd_valid/o_cmd_ready           command handshake (ready only in IDLE)
//   i_cmd_we, i_cmd_mask, i_cmd_value command fields
//   o_wb_cyc/stb/we/addr/data/sel     Wishbone request side
//   i_wb_stall/ack/err/data           Wishbone response side
//   o_rsp_valid/err/data              one-cycle command completion report
//   o_gpio_in, o_int                  polled input half and change pulse
// ============================================================================
module wbgpio_driver
    import wbgpio_driver_pkg::*;
#(
    parameter int            AW          = 30,
    parameter logic [AW-1:0] GPIO_ADDR   = '0,
    parameter int            TIMEOUT     = 1024,
    parameter int            POLL_CYCLES = 100000
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_we,
    input  logic [c_field_w-1:0] i_cmd_mask,
    input  logic [c_field_w-1:0] i_cmd_value,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [AW-1:0]        o_wb_addr,
    output logic [31:0]          o_wb_data,
    output logic [3:0]           o_wb_sel,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    input  logic [31:0]          i_wb_data,
    output logic                 o_rsp_valid,
    output logic                 o_rsp_err,
    output logic [31:0]          o_rsp_data,
    output logic [c_field_w-1:0] o_gpio_in,
    output logic                 o_int
);

    localparam logic [c_tmo_cnt_w-1:0] c_tmo_load = c_tmo_cnt_w'(TIMEOUT - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic                 w_accept;
    logic                 w_poll_start;
    logic                 w_finish;
    logic                 w_fin_err;
    logic                 w_fin_ok;
    logic                 w_poll_due;
    logic                 w_tmo_expired;
    logic                 w_bus_busy;

    logic                 r_we;
    logic                 r_is_poll;
    logic                 r_err;
    logic [31:0]          r_wb_data;
    logic [31:0]          r_rd_data;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [31:0]          r_rsp_data;

    assign w_bus_busy = (r_state == c_st_req) || (r_state == c_st_wait);

    // Bus-phase timeout: reloaded whenever CYC is low, so its first count
    // lands on the CYC rise and expiry falls on the TIMEOUT-th CYC cycle.
    wbgpio_driver_timer #(
        .W         (c_tmo_cnt_w),
        .RESET_VAL (c_tmo_load)
    ) u_tmo_timer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_load       (!w_bus_busy),
        .i_load_value (c_tmo_load),
        .i_en         (w_bus_busy),
        .o_expired    (w_tmo_expired)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_poll_start = 1'b0;
        w_finish     = 1'b0;
        w_fin_err    = 1'b0;
        w_fin_ok     = 1'b0;
        case (r_state)
            c_st_idle: begin
                // A command beats a due poll; the poll timer holds at zero
                // so the poll goes out as soon as we are idle again.
                if (i_cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = c_st_req;
                end else if (w_poll_due) begin
                    w_poll_start = 1'b1;
                    w_next_state = c_st_req;
                end
            end
            c_st_req: begin
                // ACK/ERR only count once the strobe is actually accepted
                if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
                    w_finish     = 1'b1;
                    w_fin_err    = i_wb_err;
                    w_fin_ok     = !i_wb_err;
                    w_next_state = c_st_done;
                end else if (w_tmo_expired) begin
                    w_finish     = 1'b1;
                    w_fin_err    = 1'b1;
                    w_next_state = c_st_done;
                end else if (!i_wb_stall) begin
                    w_next_state = c_st_wait;
                end
            end
            c_st_wait: begin
                if (i_wb_ack || i_wb_err) begin
                    w_finish     = 1'b1;
                    w_fin_err    = i_wb_err;
                    w_fin_ok     = !i_wb_err;
                    w_next_state = c_st_done;
                end else if (w_tmo_expired) begin
                    w_finish     = 1'b1;
                    w_fin_err    = 1'b1;
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= c_st_idle;
            r_we        <= 1'b0;
            r_is_poll   <= 1'b0;
            r_err       <= 1'b0;
            r_wb_data   <= '0;
            r_rd_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;

            if (w_accept) begin
                r_we      <= i_cmd_we;
                r_is_poll <= 1'b0;
                r_wb_data <= i_cmd_we ? pack_set_clear(i_cmd_mask, i_cmd_value) : '0;
            end else if (w_poll_start) begin
                r_we      <= 1'b0;
                r_is_poll <= 1'b1;
                r_wb_data <= '0;
            end

            if (w_finish) begin
                r_err     <= w_fin_err;
                r_rd_data <= w_fin_ok ? i_wb_data : '0;
            end

            // Response is reported the cycle after DONE; polls are silent
            if ((r_state == c_st_done) && !r_is_poll) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_data  <= (r_we || r_err) ? '0 : r_rd_data;
            end
        end
    end

`ifdef WBGPIO_DRIVER_POLL_EN
    localparam int               c_poll_w    = $clog2(POLL_CYCLES);
    localparam logic [c_poll_w-1:0] c_poll_load = c_poll_w'(POLL_CYCLES - 1);

    logic                 w_poll_expired;
    logic [c_field_w-1:0] r_gpio_in;
    logic                 r_int;

    // Counts IDLE cycles only and restarts after every poll, whether the
    // poll succeeded or was dropped.
    wbgpio_driver_timer #(
        .W         (c_poll_w),
        .RESET_VAL (c_poll_load)
    ) u_poll_timer (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_load       ((r_state == c_st_done) && r_is_poll),
        .i_load_value (c_poll_load),
        .i_en         (r_state == c_st_idle),
        .o_expired    (w_poll_expired)
    );

    assign w_poll_due = w_poll_expired;

    // Comparing against the reset value of zero makes the first poll pulse
    // o_int whenever the input half is nonzero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_gpio_in <= '0;
            r_int     <= 1'b0;
        end else begin
            r_int <= 1'b0;
            if (w_fin_ok && r_is_poll) begin
                r_gpio_in <= i_wb_data[c_mask_msb:c_mask_lsb];
                r_int     <= (i_wb_data[c_mask_msb:c_mask_lsb] != r_gpio_in);
            end
        end
    end

    assign o_gpio_in = r_gpio_in;
    assign o_int     = r_int;
`else
    assign w_poll_due = 1'b0;
    assign o_gpio_in  = '0;
    assign o_int      = 1'b0;
`endif

    assign o_cmd_ready = (r_state == c_st_idle);
    assign o_wb_cyc    = w_bus_busy;
    assign o_wb_stb    = (r_state == c_st_req);
    assign o_wb_we     = r_we;
    assign o_wb_addr   = GPIO_ADDR;
    assign o_wb_data   = r_wb_data;
    assign o_wb_sel    = c_wb_sel_all;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_wbgpio_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbgpio_driver
// Description : Directed self-checking bench for wbgpio_driver. A second
//               instance with an auto-acking slave exercises the poll path
//               when WBGPIO_DRIVER_POLL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbgpio_driver;

    localparam logic [29:0] c_addr = 30'h0000_0123;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_we;
    logic [15:0] cmd_mask;
    logic [15:0] cmd_value;
    logic        cmd_ready;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [29:0] wb_addr;
    logic [31:0] wb_dout;
    logic [3:0]  wb_sel;
    logic        wb_stall;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_din;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [15:0] gpio_in;
    logic        gpio_int;

    int n_checks = 0;
    int n_errors = 0;
    int stb_cnt;
    int cyc_cnt;
    int rsp_seen;

    wbgpio_driver #(
        .AW          (30),
        .GPIO_ADDR   (c_addr),
        .TIMEOUT     (16),
        .POLL_CYCLES (50000)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_mask  (cmd_mask),
        .i_cmd_value (cmd_value),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_dout),
        .o_wb_sel    (wb_sel),
        .i_wb_stall  (wb_stall),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err),
        .i_wb_data   (wb_din),
        .o_rsp_valid (rsp_valid),
        .o_rsp_err   (rsp_err),
        .o_rsp_data  (rsp_data),
        .o_gpio_in   (gpio_in),
        .o_int       (gpio_int)
    );

`ifdef WBGPIO_DRIVER_POLL_EN
    logic        p_cmd_valid;
    logic        p_cmd_we;
    logic [15:0] p_cmd_mask;
    logic [15:0] p_cmd_value;
    logic [15:0] p_in;
    logic        p_ready;
    logic        p_cyc;
    logic        p_stb;
    logic        p_we;
    logic [29:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_sel;
    logic        p_rsp_valid;
    logic        p_rsp_err;
    logic [31:0] p_rsp_data;
    logic [15:0] p_gpio_in;
    logic        p_int;
    logic        p_ack;
    int          int_cnt = 0;
    int          gap;
    logic        found;
    logic        prev_cyc;

    assign p_ack = p_cyc & p_stb;

    wbgpio_driver #(
        .AW          (30),
        .GPIO_ADDR   (c_addr),
        .TIMEOUT     (16),
        .POLL_CYCLES (8)
    ) dut_poll (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (p_cmd_valid),
        .o_cmd_ready (p_ready),
        .i_cmd_we    (p_cmd_we),
        .i_cmd_mask  (p_cmd_mask),
        .i_cmd_value (p_cmd_value),
        .o_wb_cyc    (p_cyc),
        .o_wb_stb    (p_stb),
        .o_wb_we     (p_we),
        .o_wb_addr   (p_addr),
        .o_wb_data   (p_data),
        .o_wb_sel    (p_sel),
        .i_wb_stall  (1'b0),
        .i_wb_ack    (p_ack),
        .i_wb_err    (1'b0),
        .i_wb_data   ({p_in, 16'h0000}),
        .o_rsp_valid (p_rsp_valid),
        .o_rsp_err   (p_rsp_err),
        .o_rsp_data  (p_rsp_data),
        .o_gpio_in   (p_gpio_in),
        .o_int       (p_int)
    );

    always @(negedge clk) begin
        if (p_int) int_cnt <= int_cnt + 1;
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_mask  = '0;
        cmd_value = '0;
        wb_stall  = 1'b0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        wb_din    = '0;
`ifdef WBGPIO_DRIVER_POLL_EN
        p_cmd_valid = 1'b0;
        p_cmd_we    = 1'b0;
        p_cmd_mask  = '0;
        p_cmd_value = '0;
        p_in        = '0;
`endif
        repeat (3) tick();

        // ---------------- reset state ----------------
        chk("rst_ready",    cmd_ready, 1);
        chk("rst_cyc",      wb_cyc,    0);
        chk("rst_stb",      wb_stb,    0);
        chk("rst_we",       wb_we,     0);
        chk("rst_addr",     wb_addr,   c_addr);
        chk("rst_wdata",    wb_dout,   0);
        chk("rst_sel",      wb_sel,    4'hf);
        chk("rst_rspv",     rsp_valid, 0);
        chk("rst_rspd",     rsp_data,  0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------------- 1: write, ack with STB ----------------
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_mask = 16'h0001; cmd_value = 16'h0001;
        tick();                                   // REQ
        cmd_valid = 1'b0;
        chk("t1_cyc",   wb_cyc,  1);
        chk("t1_stb",   wb_stb,  1);
        chk("t1_we",    wb_we,   1);
        chk("t1_wdata", wb_dout, 32'h0001_0001);
        chk("t1_ready", cmd_ready, 0);
        wb_ack = 1'b1;
        tick();                                   // DONE
        wb_ack = 1'b0;
        chk("t1_done_cyc",  wb_cyc,    0);
        chk("t1_done_rspv", rsp_valid, 0);
        tick();                                   // 3 cycles after accept
        chk("t1_rspv", rsp_valid, 1);
        chk("t1_rspe", rsp_err,   0);
        chk("t1_rspd", rsp_data,  0);
        tick();
        chk("t1_rspv_pulse", rsp_valid, 0);

        // ---------------- 1b: masked write, ack in WAIT ----------------
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_mask = 16'h00F0; cmd_value = 16'hA5A5;
        tick();                                   // REQ
        cmd_valid = 1'b0;
        chk("t1b_wdata", wb_dout, 32'h00F0_00A0);
        tick();                                   // WAIT
        chk("t1b_wait_stb", wb_stb, 0);
        chk("t1b_wait_cyc", wb_cyc, 1);
        wb_ack = 1'b1;
        tick();                                   // DONE
        wb_ack = 1'b0;
        tick();
        chk("t1b_rspv", rsp_valid, 1);
        chk("t1b_rspe", rsp_err,   0);
        tick();

        // ---------------- 2: read with stall ----------------
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_mask = 16'hFFFF; cmd_value = 16'hFFFF;
        wb_stall  = 1'b1;
        tick();                                   // REQ cycle 1
        cmd_valid = 1'b0;
        chk("t2_we",    wb_we,   0);
        chk("t2_wdata", wb_dout, 0);
        stb_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (wb_stb) stb_cnt++;
            wb_stall = (i < 4);
            tick();
        end
        chk("t2_stb_len",  stb_cnt, 5);
        chk("t2_wait_stb", wb_stb,  0);
        chk("t2_wait_cyc", wb_cyc,  1);
        tick();                                   // second WAIT cycle
        wb_ack = 1'b1; wb_din = 32'hABCD_1234;
        tick();                                   // DONE
        wb_ack = 1'b0; wb_din = '0;
        chk("t2_done_cyc", wb_cyc, 0);
        tick();
        chk("t2_rspv", rsp_valid, 1);
        chk("t2_rspe", rsp_err,   0);
        chk("t2_rspd", rsp_data,  32'hABCD_1234);
        tick();
        chk("t2_rspd_held", rsp_data, 32'hABCD_1234);

        // ---------------- 3: timeout ----------------
        cmd_valid = 1'b1; cmd_we = 1'b0;
        tick();
        cmd_valid = 1'b0;
        cyc_cnt = 0;
        for (int i = 0; i < 40 && wb_cyc; i++) begin
            cyc_cnt++;
            tick();
        end
        chk("t3_cyc_len", cyc_cnt, 16);
        wb_ack = 1'b1;                            // stale ACK in DONE
        tick();
        wb_ack = 1'b0;
        chk("t3_rspv", rsp_valid, 1);
        chk("t3_rspe", rsp_err,   1);
        wb_ack = 1'b1;                            // stale ACK in IDLE
        tick();
        wb_ack = 1'b0;
        chk("t3_late_cyc",  wb_cyc,    0);
        chk("t3_late_rspv", rsp_valid, 0);
        chk("t3_late_rdy",  cmd_ready, 1);

        // ---------------- 4: ACK+ERR, valid held ----------------
        cmd_valid = 1'b1; cmd_we = 1'b0;
        tick();                                   // REQ
        chk("t4_rdy_req", cmd_ready, 0);
        wb_ack = 1'b1; wb_err = 1'b1; wb_din = 32'h5555_5555;
        tick();                                   // DONE
        wb_ack = 1'b0; wb_err = 1'b0; wb_din = '0;
        chk("t4_rdy_done", cmd_ready, 0);
        tick();
        chk("t4_rspv", rsp_valid, 1);
        chk("t4_rspe", rsp_err,   1);
        chk("t4_rdy_idle", cmd_ready, 1);
        cmd_valid = 1'b0;
        tick();

        // ---------------- 6: reset in WAIT ----------------
        cmd_valid = 1'b1; cmd_we = 1'b0;
        tick();                                   // REQ
        cmd_valid = 1'b0;
        tick();                                   // WAIT
        chk("t6_wait_cyc", wb_cyc, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_cyc", wb_cyc, 0);
        chk("t6_async_stb", wb_stb, 0);
        tick();
        rst_n = 1'b1;
        rsp_seen = 0;
        repeat (4) begin
            tick();
            if (rsp_valid) rsp_seen++;
        end
        chk("t6_no_rsp", rsp_seen,  0);
        chk("t6_ready",  cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_mask = 16'hFFFF; cmd_value = 16'h1234;
        tick();
        cmd_valid = 1'b0;
        chk("t6_rec_wdata", wb_dout, 32'hFFFF_1234);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        tick();
        chk("t6_rec_rspv", rsp_valid, 1);
        chk("t6_rec_rspe", rsp_err,   0);

        // Poll never fires on the main instance within this run
        chk("np_gpio_in", gpio_in,  0);
        chk("np_int",     gpio_int, 0);

`ifdef WBGPIO_DRIVER_POLL_EN
        // ---------------- 5: polling ----------------
        repeat (30) tick();
        chk("t5_no_int_zero", int_cnt, 0);
        p_in = 16'h0040;
        for (int i = 0; i < 30 && p_gpio_in != 16'h0040; i++) tick();
        chk("t5_gpio_in", p_gpio_in, 16'h0040);
        repeat (30) tick();
        chk("t5_one_int", int_cnt, 1);

        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            prev_cyc = p_cyc;
            tick();
            if (prev_cyc && !p_cyc) found = 1'b1;
        end
        chk("t5_sync", found, 1);
        repeat (8) tick();                        // poll-due IDLE cycle
        p_cmd_valid = 1'b1; p_cmd_we = 1'b1; p_cmd_mask = 16'h0003; p_cmd_value = 16'h0001;
        tick();
        p_cmd_valid = 1'b0;
        chk("t5_cmd_cyc",   p_cyc,  1);
        chk("t5_cmd_we",    p_we,   1);
        chk("t5_cmd_wdata", p_data, 32'h0003_0001);
        tick();
        gap = 0;
        for (int i = 0; i < 6 && !p_cyc; i++) begin
            gap++;
            tick();
        end
        chk("t5_poll_gap", gap,  2);
        chk("t5_poll_we",  p_we, 0);
        repeat (4) tick();
        chk("t5_no_more_int", int_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
